// File: rtl/rete_ricomposizione_byte_pkg.sv
// Shared definitions for the nibble-to-byte reassembly path: FSM state
// encoding and datapath widths.
package rete_ricomposizione_byte_pkg;

    localparam int NIB_W  = 4;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        S_PRIMO   = 2'b00,
        S_SECONDO = 2'b01,
        S_USCITA  = 2'b10
    } stato_t;

endpackage

// File: rtl/rete_ricomposizione_byte_calcolo_parita.sv
// Even-parity checker over a byte plus its parity bit; err_o=1 flags a mismatch.
module calcolo_parita
    import rete_ricomposizione_byte_pkg::*;
(
    input  logic [BYTE_W-1:0] byte_i,
    input  logic              p_i,
    output logic              err_o
);

    assign err_o = ^{byte_i, p_i};

endmodule

// File: rtl/rete_ricomposizione_byte.sv
// Reassembles pairs of 4-bit nibbles into bytes across two valid/ready links,
// counts delivered bytes, and checks parity when PARITY_CHK_EN is defined.
module rete_ricomposizione_byte
    import rete_ricomposizione_byte_pkg::*;
#(
    parameter int HI_FIRST = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NIB_W-1:0]  x3_x0,
    input  logic              p_in,
    input  logic              dav_in,
    output logic              rfd_in,
    output logic [BYTE_W-1:0] z7_z0,
    output logic              dav_out,
    input  logic              rfd_out,
    output logic              err,
    output logic [BYTE_W-1:0] n_byte
);

    // Handshake: a nibble moves on a rising edge with dav_in & rfd_in, a byte
    // on a rising edge with dav_out & rfd_out; the data must be held stable
    // while its valid is high, and both ready/valid outputs depend on state only.

    stato_t              stato_q;
    logic [BYTE_W-1:0]   byte_q, byte_d;
    logic [BYTE_W-1:0]   n_byte_q, n_byte_d;
    logic                err_q, err_d;

    generate
        if (HI_FIRST != 0) begin : g_hi_first
            assign byte_d = {byte_q[BYTE_W-1:NIB_W], x3_x0};
        end else begin : g_lo_first
            assign byte_d = {x3_x0, byte_q[NIB_W-1:0]};
        end
    endgenerate

`ifdef PARITY_CHK_EN
    calcolo_parita u_calcolo_parita (
        .byte_i (byte_d),
        .p_i    (p_in),
        .err_o  (err_d)
    );
`else
    logic p_in_unused;
    assign p_in_unused = p_in;
    assign err_d       = 1'b0;
`endif

    assign n_byte_d = n_byte_q + 8'd1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stato_q  <= S_PRIMO;
            byte_q   <= '0;
            err_q    <= 1'b0;
            n_byte_q <= '0;
        end else begin
            case (stato_q)
                S_PRIMO: begin
                    if (dav_in) begin
                        if (HI_FIRST != 0) byte_q[BYTE_W-1:NIB_W] <= x3_x0;
                        else               byte_q[NIB_W-1:0]      <= x3_x0;
                        stato_q <= S_SECONDO;
                    end
                end
                S_SECONDO: begin
                    if (dav_in) begin
                        byte_q  <= byte_d;
                        err_q   <= err_d;
                        stato_q <= S_USCITA;
                    end
                end
                S_USCITA: begin
                    // byte_q and err_q stay frozen until the consumer takes the byte
                    if (rfd_out) begin
                        n_byte_q <= n_byte_d;
                        err_q    <= 1'b0;
                        stato_q  <= S_PRIMO;
                    end
                end
                default: stato_q <= S_PRIMO;
            endcase
        end
    end

    assign rfd_in  = (stato_q == S_PRIMO) || (stato_q == S_SECONDO);
    assign dav_out = (stato_q == S_USCITA);
    assign z7_z0   = byte_q;
    assign err     = err_q;
    assign n_byte  = n_byte_q;

endmodule

// File: tb/tb_rete_ricomposizione_byte.sv
// Bench for rete_ricomposizione_byte: HI_FIRST=1 and HI_FIRST=0 instances share one stimulus stream.
module tb_rete_ricomposizione_byte;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] x3_x0;
    logic       p_in;
    logic       dav_in;
    logic       rfd_out;

    logic       rfd_in_h, dav_out_h, err_h;
    logic [7:0] z_h, n_byte_h;
    logic       rfd_in_l, dav_out_l, err_l;
    logic [7:0] z_l, n_byte_l;

    logic [7:0] exp_h_q[$];
    logic [7:0] exp_l_q[$];
    logic       exp_e_q[$];
    logic [7:0] cnt_exp;
    int         n_pass = 0;
    int         n_chk  = 0;

    always #5 clock = ~clock;

    rete_ricomposizione_byte #(.HI_FIRST(1)) dut_h (
        .clock(clock), .reset(reset), .x3_x0(x3_x0), .p_in(p_in),
        .dav_in(dav_in), .rfd_in(rfd_in_h), .z7_z0(z_h), .dav_out(dav_out_h),
        .rfd_out(rfd_out), .err(err_h), .n_byte(n_byte_h)
    );

    rete_ricomposizione_byte #(.HI_FIRST(0)) dut_l (
        .clock(clock), .reset(reset), .x3_x0(x3_x0), .p_in(p_in),
        .dav_in(dav_in), .rfd_in(rfd_in_l), .z7_z0(z_l), .dav_out(dav_out_l),
        .rfd_out(rfd_out), .err(err_l), .n_byte(n_byte_l)
    );

    function automatic logic exp_err(input logic [7:0] b, input logic p);
`ifdef PARITY_CHK_EN
        return ^{b, p};
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send_nibble(input logic [3:0] nib, input logic p);
        int bound;
        @(negedge clock);
        dav_in = 1'b1;
        x3_x0  = nib;
        p_in   = p;
        bound  = 0;
        while (rfd_in_h !== 1'b1 && bound < 100) begin
            @(negedge clock);
            bound++;
        end
        chk("nibble_timeout", 8'(bound < 100), 8'd1);
        @(posedge clock);
        #1 dav_in = 1'b0;
    endtask

    task automatic send_pair(input logic [3:0] a, input logic [3:0] b, input logic p);
        send_nibble(a, 1'b0);
        send_nibble(b, p);
        exp_h_q.push_back({a, b});
        exp_l_q.push_back({b, a});
        exp_e_q.push_back(exp_err({a, b}, p));
    endtask

    task automatic recv_byte();
        int bound;
        @(negedge clock);
        rfd_out = 1'b1;
        bound   = 0;
        while (dav_out_h !== 1'b1 && bound < 100) begin
            @(negedge clock);
            bound++;
        end
        chk("byte_timeout", 8'(bound < 100), 8'd1);
        chk("sb_nonempty", 8'(exp_h_q.size() != 0), 8'd1);
        if (exp_h_q.size() != 0) begin
            chk("z_hi_first", z_h, exp_h_q.pop_front());
            chk("z_lo_first", z_l, exp_l_q.pop_front());
            chk("err_out", 8'({err_h, err_l}), 8'({2{exp_e_q.pop_front()}}));
        end
        chk("dav_out_lo", 8'(dav_out_l), 8'd1);
        @(posedge clock);
        #1 rfd_out = 1'b0;
        cnt_exp++;
        chk("n_byte_h", n_byte_h, cnt_exp);
        chk("n_byte_l", n_byte_l, cnt_exp);
        chk("post_xfer_idle", 8'({dav_out_h, rfd_in_h, err_h, err_l}), 8'b0100);
    endtask

    initial begin
        reset   = 1'b1;
        x3_x0   = '0;
        p_in    = 1'b0;
        dav_in  = 1'b0;
        rfd_out = 1'b0;
        cnt_exp = '0;

        // reset values
        repeat (2) @(negedge clock);
        chk("rst_ctrl_h", 8'({rfd_in_h, dav_out_h, err_h}), 8'b100);
        chk("rst_ctrl_l", 8'({rfd_in_l, dav_out_l, err_l}), 8'b100);
        chk("rst_z_h", z_h, 8'h00);
        chk("rst_n_byte", n_byte_h, 8'h00);
        reset = 1'b0;

        // back-to-back A,5 with consumer always ready: byte visible in cycle 3
        @(negedge clock);
        dav_in = 1'b1; x3_x0 = 4'hA; p_in = 1'b0; rfd_out = 1'b1;
        @(posedge clock); #1;
        chk("t1_c1_ctrl", 8'({rfd_in_h, dav_out_h}), 8'b10);
        @(negedge clock);
        x3_x0 = 4'h5;
        @(posedge clock); #1;
        dav_in = 1'b0;
        chk("t1_c3_ctrl", 8'({rfd_in_h, dav_out_h, rfd_in_l, dav_out_l}), 8'b0101);
        chk("t1_z_h", z_h, 8'hA5);
        chk("t1_z_l", z_l, 8'h5A);
        chk("t1_err", 8'(err_h), 8'(exp_err(8'hA5, 1'b0)));
        @(posedge clock); #1;
        rfd_out = 1'b0;
        cnt_exp++;
        chk("t1_n_byte", n_byte_h, 8'd1);
        chk("t1_idle", 8'({rfd_in_h, dav_out_h}), 8'b10);

        // 3 then C: HI_FIRST=0 gives C3
        send_pair(4'h3, 4'hC, 1'b0);
        recv_byte();

        // consumer stall with a pending nibble F
        send_pair(4'h1, 4'h2, 1'b1);
        @(negedge clock);
        dav_in = 1'b1; x3_x0 = 4'hF; p_in = 1'b0;
        repeat (5) begin
            @(negedge clock);
            chk("stall_ctrl", 8'({rfd_in_h, dav_out_h, rfd_in_l, dav_out_l}), 8'b0101);
            chk("stall_z_h", z_h, exp_h_q[0]);
            chk("stall_z_l", z_l, exp_l_q[0]);
            chk("stall_err", 8'(err_h), 8'(exp_e_q[0]));
        end
        recv_byte();
        // F still on the link is taken on the very next edge
        dav_in = 1'b1;
        @(posedge clock); #1;
        dav_in = 1'b0;
        send_nibble(4'h0, 1'b0);
        exp_h_q.push_back(8'hF0);
        exp_l_q.push_back(8'h0F);
        exp_e_q.push_back(exp_err(8'hF0, 1'b0));
        chk("stall_follow_dav", 8'(dav_out_h), 8'd1);
        recv_byte();

        // parity: A5 with p=0 then p=1
        send_pair(4'hA, 4'h5, 1'b0);
        recv_byte();
        send_pair(4'hA, 4'h5, 1'b1);
        @(negedge clock);
        chk("par_err_hold", 8'(err_h), 8'(exp_err(8'hA5, 1'b1)));
        recv_byte();

        // asynchronous reset after first nibble 7
        send_nibble(4'h7, 1'b0);
        #3 reset = 1'b1;
        #1;
        chk("arst_ctrl", 8'({rfd_in_h, dav_out_h, rfd_in_l, dav_out_l}), 8'b1010);
        chk("arst_n_byte", n_byte_h, 8'h00);
        cnt_exp = '0;
        @(negedge clock);
        reset = 1'b0;
        send_pair(4'h1, 4'h2, 1'b0);
        recv_byte();

        // run the byte counter through its wrap
        for (int i = 0; i < 300 && cnt_exp != 8'd0; i++) begin
            send_pair(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      1'($urandom_range(0, 1)));
            recv_byte();
        end
        chk("wrap_n_byte_h", n_byte_h, 8'h00);
        chk("wrap_n_byte_l", n_byte_l, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
